// File: rtl/slink_crc_append.sv
// slink_crc_append: byte-stream pass-through that optionally appends a CRC-16/MCRF4XX trailer per packet.
module slink_crc_append #(
  parameter bit LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        crc_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [15:0] crc_value
);
  typedef enum logic [1:0] {PAYLOAD, CRC_A, CRC_B} state_t;
  state_t state, state_nx;
  logic [15:0] acc, crc_nx;
  logic [7:0] crc_first, crc_second;
  logic en_l, pkt_start, a_loaded, accept, en_eff;
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 16'h8408 : r >> 1;
    return r;
  endfunction
  assign accept     = in_valid && in_ready;
  assign en_eff     = pkt_start ? crc_en : en_l;
  assign crc_nx     = crc_byte(acc, in_data);
  assign crc_first  = LSB_FIRST ? crc_value[7:0] : crc_value[15:8];
  assign crc_second = LSB_FIRST ? crc_value[15:8] : crc_value[7:0];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= PAYLOAD;
    else state <= state_nx;
  end
  // CRC_A spans the last payload byte draining and then the first CRC byte on the output register
  always_comb begin
    state_nx = state;
    if (state == PAYLOAD && accept && in_last && en_eff) state_nx = CRC_A;
    else if (state == CRC_A && out_ready && a_loaded) state_nx = CRC_B;
    else if (state == CRC_B && out_ready) state_nx = PAYLOAD;
  end
  always_comb begin
    in_ready = reset_n && state == PAYLOAD && (!out_valid || out_ready);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      acc       <= 16'hFFFF;
      crc_value <= 16'hFFFF;
      en_l      <= 1'b0;
      pkt_start <= 1'b1;
      a_loaded  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last && !en_eff;
      pkt_start <= in_last;
      a_loaded  <= 1'b0;
      if (pkt_start) en_l <= crc_en;
      if (in_last) acc <= 16'hFFFF;
      else if (en_eff) acc <= crc_nx;
      if (in_last && en_eff) crc_value <= crc_nx;
    end else if (state == CRC_A && out_ready) begin
      out_data <= a_loaded ? crc_second : crc_first;
      out_last <= a_loaded;
      a_loaded <= 1'b1;
    end else if (state != CRC_A && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_slink_crc_append.sv
// tb_slink_crc_append: directed checks of payload pass-through, CRC trailer, stalls and reset.
module tb_slink_crc_append;
  logic clk = 0, reset_n = 0, in_valid = 0, in_last = 0, crc_en = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic in_ready, out_valid, out_last, in_ready_b, out_valid_b, out_last_b;
  logic [7:0] out_data, out_data_b;
  logic [15:0] crc_value, crc_value_b;
  int errors = 0, checks = 0;
  logic [7:0] qd[$], qb[$];
  logic ql[$];
  bit fired;
  logic [7:0] msg[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  logic [7:0] exp11[11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};

  slink_crc_append dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .crc_en(crc_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .crc_value(crc_value)
  );
  slink_crc_append #(.LSB_FIRST(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_last(in_last), .crc_en(crc_en), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_last(out_last_b), .crc_value(crc_value_b)
  );

  always #5 clk = ~clk;

  task automatic step(input bit ordy);
    out_ready = ordy;
    #1;
    fired = in_valid && in_ready;
    if (out_valid && out_ready) begin qd.push_back(out_data); ql.push_back(out_last); end
    if (out_valid_b && out_ready) qb.push_back(out_data_b);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit last, input bit en, input int pct);
    int n = 0;
    in_valid = 1; in_data = b; in_last = last; crc_en = en;
    do begin step($urandom_range(99) < pct); n++; end while (!fired && n < 400);
    if (!fired) begin errors++; checks++; $display("FAIL send_timeout byte=%h", b); end
    in_valid = 0; in_last = 0;
  endtask

  task automatic send_msg(input bit en);
    for (int i = 0; i < 9; i++) send(msg[i], i == 8, en, 100);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks += 5;
    if (out_valid !== 0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h want=00", out_data); end
    if (out_last !== 0) begin errors++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    if (in_ready !== 0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    if (crc_value !== 16'hFFFF) begin errors++; $display("FAIL reset_crc got=%h want=ffff", crc_value); end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_known;
    qd.delete(); ql.delete(); qb.delete();
    send_msg(1);
    drain(5);
    checks += 4;
    if (qd.size() != 11) begin errors++; $display("FAIL known_count got=%0d want=11", qd.size()); end
    if (qb.size() != 11) begin errors++; $display("FAIL known_count_msb got=%0d want=11", qb.size()); end
    for (int i = 0; i < 11 && i < qd.size(); i++) begin
      checks++;
      if (qd[i] !== exp11[i] || ql[i] !== (i == 10))
        begin errors++; $display("FAIL known_byte%0d got=%h/%b want=%h/%b", i, qd[i], ql[i], exp11[i], i == 10); end
    end
    if (crc_value !== 16'h6F91) begin errors++; $display("FAIL known_crc got=%h want=6f91", crc_value); end
    if (qb.size() == 11 && (qb[9] !== 8'h6F || qb[10] !== 8'h91))
      begin errors++; $display("FAIL msb_order got=%h,%h want=6f,91", qb[9], qb[10]); end
    checks++;
    if (crc_value_b !== 16'h6F91) begin errors++; $display("FAIL msb_crc got=%h want=6f91", crc_value_b); end
  endtask

  task automatic test_single;
    logic [7:0] ed[3] = '{8'h00, 8'h87, 8'h0F};
    qd.delete(); ql.delete();
    send(8'h00, 1, 1, 100);
    drain(5);
    checks += 2;
    if (qd.size() != 3) begin errors++; $display("FAIL single_count got=%0d want=3", qd.size()); end
    for (int i = 0; i < 3 && i < qd.size(); i++) begin
      checks++;
      if (qd[i] !== ed[i] || ql[i] !== (i == 2))
        begin errors++; $display("FAIL single_byte%0d got=%h/%b want=%h/%b", i, qd[i], ql[i], ed[i], i == 2); end
    end
    if (crc_value !== 16'h0F87) begin errors++; $display("FAIL single_crc got=%h want=0f87", crc_value); end
  endtask

  task automatic test_passthru;
    logic [7:0] pk[4] = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
    qd.delete(); ql.delete();
    for (int i = 0; i < 4; i++) send(pk[i], i == 3, 0, 100);
    drain(5);
    checks += 2;
    if (qd.size() != 4) begin errors++; $display("FAIL pass_count got=%0d want=4", qd.size()); end
    for (int i = 0; i < 4 && i < qd.size(); i++) begin
      checks++;
      if (qd[i] !== pk[i] || ql[i] !== (i == 3))
        begin errors++; $display("FAIL pass_byte%0d got=%h/%b want=%h/%b", i, qd[i], ql[i], pk[i], i == 3); end
    end
    if (crc_value !== 16'h0F87) begin errors++; $display("FAIL pass_crc_held got=%h want=0f87", crc_value); end
  endtask

  task automatic test_stall;
    int i = 0, n = 0;
    logic pv = 0, pl = 0;
    logic [7:0] pd = 0;
    qd.delete(); ql.delete();
    crc_en = 1;
    while ((i < 9 || qd.size() < 11) && n < 1000) begin
      in_valid = i < 9; in_data = msg[i < 9 ? i : 8]; in_last = i == 8;
      out_ready = $urandom_range(1);
      #1;
      if (pv) begin
        checks++;
        if (!out_valid || out_data !== pd || out_last !== pl)
          begin errors++; $display("FAIL stall_hold got=%b/%h/%b want=1/%h/%b", out_valid, out_data, out_last, pd, pl); end
      end
      pv = out_valid && !out_ready; pd = out_data; pl = out_last;
      if (in_valid && in_ready) i++;
      if (out_valid && out_ready) begin qd.push_back(out_data); ql.push_back(out_last); end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    in_valid = 0; in_last = 0;
    drain(4);
    checks += 2;
    if (qd.size() != 11) begin errors++; $display("FAIL stall_count got=%0d want=11", qd.size()); end
    for (int k = 0; k < 11 && k < qd.size(); k++) begin
      checks++;
      if (qd[k] !== exp11[k] || ql[k] !== (k == 10))
        begin errors++; $display("FAIL stall_byte%0d got=%h/%b want=%h/%b", k, qd[k], ql[k], exp11[k], k == 10); end
    end
    if (crc_value !== 16'h6F91) begin errors++; $display("FAIL stall_crc got=%h want=6f91", crc_value); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ed[3] = '{8'h00, 8'h87, 8'h0F};
    send_msg(1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready !== (k == 3)) begin errors++; $display("FAIL b2b_in_ready%0d got=%b want=%b", k, in_ready, k == 3); end
      step(1);
    end
    qd.delete(); ql.delete();
    send(8'h00, 1, 1, 100);
    drain(5);
    checks += 2;
    if (qd.size() != 3) begin errors++; $display("FAIL b2b_count got=%0d want=3", qd.size()); end
    for (int i = 0; i < 3 && i < qd.size(); i++) begin
      checks++;
      if (qd[i] !== ed[i] || ql[i] !== (i == 2))
        begin errors++; $display("FAIL b2b_byte%0d got=%h/%b want=%h/%b", i, qd[i], ql[i], ed[i], i == 2); end
    end
    if (crc_value !== 16'h0F87) begin errors++; $display("FAIL b2b_crc got=%h want=0f87", crc_value); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) send(msg[i], 0, 1, 100);
    reset_n = 0;
    #1;
    checks += 3;
    if (out_valid !== 0) begin errors++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
    if (in_ready !== 0) begin errors++; $display("FAIL mid_in_ready got=%b want=0", in_ready); end
    if (crc_value !== 16'hFFFF) begin errors++; $display("FAIL mid_crc got=%h want=ffff", crc_value); end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    qd.delete(); ql.delete();
    send_msg(1);
    drain(5);
    checks += 2;
    if (qd.size() != 11) begin errors++; $display("FAIL mid_count got=%0d want=11", qd.size()); end
    else if (qd[9] !== 8'h91 || qd[10] !== 8'h6F || ql[10] !== 1)
      begin errors++; $display("FAIL mid_trailer got=%h,%h want=91,6f", qd[9], qd[10]); end
    if (crc_value !== 16'h6F91) begin errors++; $display("FAIL mid_final_crc got=%h want=6f91", crc_value); end
  endtask

  initial begin
    test_reset();
    test_known();
    test_single();
    test_passthru();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/slink_crc_append.md
SLINK_CRC_APPEND -- requirements
Module: slink_crc_append

Interface
REQ-001 Parameter: LSB_FIRST, default 1, 1 = CRC low byte emitted first then high byte, 0 = high byte first.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream byte valid.
REQ-005 in_ready  output  1  block accepts in_data this cycle when in_valid && in_ready.
REQ-006 in_data  input  8  payload byte.
REQ-007 in_last  input  1  marks final payload byte of a packet.
REQ-008 crc_en  input  1  sampled with first byte of a packet; 1 = append CRC, 0 = pass packet unmodified.
REQ-009 out_valid  output  1  output byte valid.
REQ-010 out_ready  input  1  downstream accepts out_data when out_valid && out_ready.
REQ-011 out_data  output  8  output byte (payload or CRC).
REQ-012 out_last  output  1  marks final byte of the output packet.
REQ-013 crc_value  output  16  final CRC of the most recently completed packet, held until the next packet completes.

Function
REQ-014 CRC SHALL be CRC-16/MCRF4XX: reflected poly 0x8408, init 0xFFFF, refin/refout true, xorout 0x0000, one byte per accepted beat, bit 0 processed first.
REQ-015 FSM states SHALL be PAYLOAD, CRC_A, CRC_B; reset state PAYLOAD.
REQ-016 Output SHALL be one register stage: accepted byte appears on out_data the cycle after acceptance (latency 1).
REQ-017 In PAYLOAD, in_ready SHALL equal (!out_valid || out_ready); in_ready SHALL be 0 in CRC_A and CRC_B.
REQ-018 Accumulator SHALL update only on accepted payload beats of CRC-enabled packets; it SHALL hold on stall cycles.
REQ-019 First accepted byte after reset or after a packet's in_last byte is packet start; crc_en SHALL be latched then and held for the whole packet.
REQ-020 Accepting in_last with latched crc_en=1: byte output with out_last=0; final CRC (including that byte) loaded into crc_value; accumulator reset to 0xFFFF; next state CRC_A.
REQ-021 CRC_A SHALL present first CRC byte (crc_value[7:0] if LSB_FIRST=1 else [15:8]) with out_last=0; advance to CRC_B when out_ready.
REQ-022 CRC_B SHALL present second CRC byte with out_last=1; on out_ready return to PAYLOAD with out_valid cleared unless a new byte is accepted the same cycle (not possible since in_ready=0; first byte of next packet accepted earliest the cycle after).
REQ-023 Accepting in_last with latched crc_en=0: byte output with out_last=1; no CRC bytes; crc_value unchanged; accumulator reset to 0xFFFF; stay in PAYLOAD.
REQ-024 Single-byte packets (first byte carries in_last) SHALL be handled per REQ-020/REQ-023.
REQ-025 out_valid SHALL stay asserted and out_data/out_last stable while out_valid && !out_ready.
REQ-026 Simultaneous output drain and input accept in PAYLOAD SHALL sustain one byte per cycle with no bubble.

Reset
REQ-027 On reset_n low, asynchronously: state PAYLOAD, out_valid 0, out_data 0x00, out_last 0, in_ready 0 while reset_n low, accumulator 0xFFFF, crc_value 0xFFFF, latched crc_en 0, packet-start flag set.
REQ-028 Reset mid-packet SHALL discard the partial packet and any pending CRC bytes; first accepted byte after release is a packet start.

Verification
REQ-029 crc_en=1, bytes 0x31..0x39 ("123456789"), out_ready=1 -> 9 payload bytes then 0x91, 0x6F (out_last on 0x6F), crc_value=0x6F91; LSB_FIRST=0 -> 0x6F, 0x91.
REQ-030 crc_en=1, single byte 0x00 with in_last -> out 0x00 (out_last=0), 0x87, 0x0F (out_last=1), crc_value=0x0F87.
REQ-031 crc_en=0, 4-byte packet -> same 4 bytes, out_last on 4th, no extra bytes, crc_value unchanged.
REQ-032 "123456789" with out_ready toggling randomly (~50%) -> identical output sequence and crc_value=0x6F91, no byte lost or duplicated, outputs stable while stalled.
REQ-033 Back-to-back packets "123456789" then 0x00 with crc_en=1 -> second packet CRC 0x0F87 (accumulator reinitialised), in_ready low exactly during CRC_A/CRC_B.
REQ-034 reset_n pulsed low after 5 bytes of a packet -> out_valid 0 immediately; subsequent "123456789" packet yields 0x91, 0x6F.
